// File: rtl/access_enable_reader_pkg.sv
// rtl/access_enable_reader_pkg.sv - shared types and constants for the access-enable reader
//
// Purpose : occupancy state encoding and store depth used by the reader top
//           and its storage sub-module.
package access_enable_reader_pkg;

  localparam int DEPTH = 2;

  // Encoding equals the number of stored entries, so the state register
  // doubles as the occupancy output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/access_enable_reader_storage.sv
// rtl/access_enable_reader_storage.sv - 2-entry register file for the access-enable reader
//
// Purpose : holds up to DEPTH words between the source pop and the stream
//           transfer. One write port, one asynchronous read port.
// Ports   : i_clock, i_resetn      clock, asynchronous active-low reset
//           i_wr_en/i_wr_ptr/i_wr_data  write port
//           i_rd_ptr, o_rd_data    read port (combinational)
import access_enable_reader_pkg::*;

module access_enable_reader_storage #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_wr_en,
  input  logic             i_wr_ptr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ptr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_entry [DEPTH];

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_entry[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_entry[i_rd_ptr];

endmodule

// File: rtl/access_enable_reader.sv
// rtl/access_enable_reader.sv - drains an access-enable source into a valid/ready stream
//
// Purpose : pops a read_enable/empty/read_data source into a 2-entry store and
//           presents the store head as a valid/ready stream. The pop request
//           depends only on registered state and source_empty, never on
//           output_ready.
// Ports   : clock, resetn                      clock, asynchronous active-low reset
//           source_empty, source_read_enable,
//           source_read_data                   access-enable source side
//           output_valid, output_ready,
//           output_data                        stream side
//           occupancy                          entries held (0..2)
// Build   : ACCESS_ENABLE_READER_BYPASS_EN adds a zero-latency path from the
//           source to the output while the store is empty.
import access_enable_reader_pkg::*;

module access_enable_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             source_empty,
  output logic             source_read_enable,
  input  logic [WIDTH-1:0] source_read_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_data,
  output logic [1:0]       occupancy
);

  occ_state_e       r_state;
  occ_state_e       w_state_nxt;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic             w_has_data;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_store_data;

  assign w_has_data         = (r_state != ST_EMPTY);
  assign source_read_enable = resetn & ~source_empty & (r_state != ST_TWO);

`ifdef ACCESS_ENABLE_READER_BYPASS_EN
  // Source head is offered directly while nothing is stored; resetn keeps
  // the output quiet during reset even though the source may be non-empty.
  assign w_bypass = resetn & ~w_has_data & ~source_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word accepted in the same cycle never enters the store.
  assign w_push = source_read_enable & ~(w_bypass & output_ready);
  assign w_pop  = w_has_data & output_ready;

  assign output_valid = w_has_data | w_bypass;
  assign output_data  = w_has_data ? w_store_data :
                        (w_bypass ? source_read_data : '0);
  assign occupancy    = r_state;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = ST_TWO;
        else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_EMPTY;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  access_enable_reader_storage #(
    .WIDTH (WIDTH)
  ) u_storage (
    .i_clock   (clock),
    .i_resetn  (resetn),
    .i_wr_en   (w_push),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (source_read_data),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_store_data)
  );

endmodule
